adder: RTL and testbench
========================

# adder

Registered WIDTH-bit two's-complement adder/subtractor with status flags and valid handshake. Takes operands `inA`/`inB` and a mode bit, and produces the modulo-2^WIDTH result with carry, signed-overflow and zero flags one clock later. It is the basic arithmetic leaf for datapath blocks that need a pipelined, flag-producing add.

## Interface
- `WIDTH`, default 5: operand and result width in bits; legal range ≥ 2.
- `clk`  input  1: rising-edge clock; sole clock domain.
- `rst_n`  input  1: asynchronous, active-low reset.
- `in_valid`  input  1: operands and mode are sampled on this cycle's rising edge when high.
- `sub`  input  1: mode select; 0 = A+B, 1 = A−B.
- `inA`  input  WIDTH: operand A, unsigned or two's complement.
- `inB`  input  WIDTH: operand B, unsigned or two's complement.
- `ans`  output  WIDTH: registered result, modulo 2^WIDTH.
- `cout`  output  1: registered carry-out of the MSB.
- `ovf`  output  1: registered signed-overflow flag.
- `zero`  output  1: registered flag, high when `ans` == 0.
- `out_valid`  output  1: high for exactly the cycle after an accepted `in_valid`.

## Operation
- Core computation: S = inA + (sub ? ~inB : inB) + sub, evaluated at WIDTH+1 bits.
- `ans` = S[WIDTH−1:0]. Overflowing results wrap.
- `cout` = S[WIDTH].
  - Add mode: unsigned carry.
  - Sub mode: 1 means no borrow (inA ≥ inB unsigned).
- `ovf`, add mode: operands have equal sign bits and the result sign differs.
- `ovf`, sub mode: operand sign bits differ and the result sign differs from inA's sign.
- `zero` = (ans == 0), computed from the registered result value.
- `in_valid` high at a rising edge: `ans`, `cout`, `ovf`, `zero` load the new values and `out_valid` goes high.
- `in_valid` low at a rising edge: `ans`, `cout`, `ovf`, `zero` hold their previous values and `out_valid` goes low.
- No backpressure: a new operation is accepted every cycle that `in_valid` is high.
- No internal state beyond the output registers; there is no state machine.

## Timing
- Reset asserted (`rst_n` = 0): immediately and asynchronously, `ans` = 0, `cout` = 0, `ovf` = 0, `out_valid` = 0, `zero` = 1 (consistent with `ans` = 0).
- Reset released: the first edge where `in_valid` is sampled is the first rising edge after `rst_n` deasserts.
- Latency: 1 cycle.
  - Operands sampled at edge N appear on the outputs after edge N.
  - `out_valid` is high from edge N until edge N+1.
- Back-to-back: inputs valid at edges N and N+1 give two consecutive result cycles; `out_valid` stays high across both.
- Reset mid-operation: an accepted operation is discarded; outputs return to reset values and no stale result appears after release.
- Inputs are combinationally unused outside the sampling edge; glitches between edges have no effect.

## Test plan
- Reset: hold `rst_n` = 0 with arbitrary inputs → `ans` = 0, `cout` = 0, `ovf` = 0, `zero` = 1, `out_valid` = 0.
- Basic add: inA = 1, inB = 2, sub = 0, valid for 1 cycle, then inA = 3, inB = 2 the next cycle → `ans` = 3 then `ans` = 5, `out_valid` high for both cycles, `cout` = 0, `ovf` = 0.
- Wrap (WIDTH = 5): 31 + 1 → `ans` = 0, `cout` = 1, `zero` = 1, `ovf` = 0. Then 15 + 1 → `ans` = 16, `ovf` = 1, `cout` = 0.
- Subtract: 3 − 2 → `ans` = 1, `cout` = 1. Then 2 − 3 → `ans` = 31, `cout` = 0, `ovf` = 0. Then 16 − 1 → `ans` = 15, `ovf` = 1.
- Hold: after a valid op, drop `in_valid` and change the operands → outputs unchanged, `out_valid` = 0.
- Reset mid-stream: assert `rst_n` low asynchronously between edges while results are valid → outputs immediately at reset values; first result after release corresponds to the first post-release valid input.

Source files
------------

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
//  Module   : adder
//  Purpose  : Registered WIDTH-bit two's-complement adder/subtractor with
//             carry, signed-overflow and zero flags and a one-cycle valid
//             handshake. One operation is accepted on every rising edge
//             where in_valid is high, and its result appears after that edge.
//
//  Ports    : clk        - rising-edge clock, sole clock domain
//             rst_n      - asynchronous active-low reset
//             in_valid   - sample operands and mode on this edge
//             sub        - 0: inA + inB, 1: inA - inB
//             inA, inB   - WIDTH-bit operands (unsigned or two's complement)
//             ans        - registered result, modulo 2^WIDTH
//             cout       - registered carry-out (sub: 1 = no borrow)
//             ovf        - registered signed-overflow flag
//             zero       - high when ans == 0
//             out_valid  - high for the cycle after an accepted in_valid
//
//  Revision : 1.0 - initial release
// ============================================================================
module adder #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             sub,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic [WIDTH-1:0] ans,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             out_valid
);

    localparam int c_MSB = WIDTH - 1;

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;

    logic [WIDTH-1:0] r_ans;
    logic             r_cout;
    logic             r_ovf;
    logic             r_valid;

    // Subtraction is A + ~B + 1; the "+1" enters as the carry-in.
    assign w_b_eff = sub ? ~inB : inB;
    assign w_sum   = {1'b0, inA} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, sub};

    // Signed overflow: the two addends (A and the effective B) share a sign
    // and the result sign differs from it. With the inverted B this covers
    // the subtract case without a separate expression.
    assign w_ovf = (inA[c_MSB] == w_b_eff[c_MSB]) && (w_sum[c_MSB] != inA[c_MSB]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ans   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_ans  <= w_sum[WIDTH-1:0];
                r_cout <= w_sum[WIDTH];
                r_ovf  <= w_ovf;
            end
        end
    end

    assign ans       = r_ans;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign out_valid = r_valid;
    // Derived from the held result register, so it tracks ans in reset too.
    assign zero      = (r_ans == '0);

endmodule
`default_nettype wire

// File: tb/tb_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder
//  Purpose  : Self-checking bench for adder (WIDTH = 5). Directed cases plus
//             random operations are compared against an integer-arithmetic
//             reference model of add/subtract with carry, overflow and zero.
//
//  Ports    : none
//
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder;

    localparam int  c_W   = 5;
    localparam longint c_MOD  = 64'sd1 << c_W;
    localparam longint c_HALF = 64'sd1 << (c_W - 1);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             sub;
    logic [c_W-1:0]   inA;
    logic [c_W-1:0]   inB;
    logic [c_W-1:0]   ans;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             out_valid;

    int vectors;
    int miscompares;

    // Reference model state (what the outputs should currently show).
    longint exp_ans;
    bit     exp_cout;
    bit     exp_ovf;
    bit     exp_valid;

    adder #(.WIDTH(c_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .sub       (sub),
        .inA       (inA),
        .inB       (inB),
        .ans       (ans),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ans"},       32'(ans),       32'(exp_ans));
        check({tag, ".cout"},      32'(cout),      32'(exp_cout));
        check({tag, ".ovf"},       32'(ovf),       32'(exp_ovf));
        check({tag, ".zero"},      32'(zero),      32'(exp_ans == 0));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
    endtask

    task automatic model_reset();
        exp_ans   = 0;
        exp_cout  = 0;
        exp_ovf   = 0;
        exp_valid = 0;
    endtask

    // Plain integer arithmetic: unsigned and signed interpretations of the
    // operands, then range checks for carry/borrow and signed overflow.
    task automatic model_op(input bit s, input longint a, input longint b);
        longint sa, sb, ures, sres;
        sa = (a >= c_HALF) ? a - c_MOD : a;
        sb = (b >= c_HALF) ? b - c_MOD : b;
        if (!s) begin
            ures     = a + b;
            sres     = sa + sb;
            exp_cout = (ures >= c_MOD);
        end else begin
            ures     = a - b;
            sres     = sa - sb;
            exp_cout = (a >= b);
        end
        exp_ans   = ((ures % c_MOD) + c_MOD) % c_MOD;
        exp_ovf   = (sres >= c_HALF) || (sres < -c_HALF);
        exp_valid = 1;
    endtask

    // Drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input string tag, input bit v, input bit s,
                        input logic [c_W-1:0] a, input logic [c_W-1:0] b);
        @(negedge clk);
        in_valid = v;
        sub      = s;
        inA      = a;
        inB      = b;
        @(posedge clk);
        #1;
        if (v) model_op(s, longint'(a), longint'(b));
        else   exp_valid = 0;
        check_all(tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b1;
        sub         = 1'b0;
        inA         = c_W'($urandom);
        inB         = c_W'($urandom);
        model_reset();

        // Reset held with valid traffic: outputs must stay at reset values.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            inA = c_W'($urandom);
            inB = c_W'($urandom);
            sub = 1'($urandom);
            @(posedge clk);
            #1;
            check_all("reset");
        end

        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // Basic add, back to back.
        step("add1+2", 1, 0, 5'd1, 5'd2);
        step("add3+2", 1, 0, 5'd3, 5'd2);
        // Wrap and signed overflow.
        step("wrap31+1", 1, 0, 5'd31, 5'd1);
        step("ovf15+1",  1, 0, 5'd15, 5'd1);
        // Subtract.
        step("sub3-2",   1, 1, 5'd3,  5'd2);
        step("sub2-3",   1, 1, 5'd2,  5'd3);
        step("sub16-1",  1, 1, 5'd16, 5'd1);
        step("sub0-16",  1, 1, 5'd0,  5'd16);
        step("sub7-7",   1, 1, 5'd7,  5'd7);
        // Hold: operands change with in_valid low.
        step("hold1", 0, 0, 5'd9,  5'd4);
        step("hold2", 0, 1, 5'd30, 5'd2);
        step("addneg", 1, 0, 5'd16, 5'd16);

        // Random traffic with random valid gaps.
        for (int i = 0; i < 200; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom),
                 c_W'($urandom), c_W'($urandom));
        end

        // Reset mid-stream: assert between edges while a result is valid.
        step("pre_rst", 1, 0, 5'd12, 5'd9);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        in_valid = 1'b1;
        inA      = 5'd5;
        inB      = 5'd6;
        @(posedge clk);
        #1;
        check_all("in_rst");
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_rst_idle");
        step("post_rst_op", 1, 1, 5'd20, 5'd4);
        step("post_rst_hold", 0, 0, 5'd1, 5'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
